io_port_buffer: RTL and testbench
=================================

Name: io_port_buffer

Overview:
- Sits between the CPU's I/O port pins (in_signal/in_data, out_signal/out_data) and the off-core host/testbench.
- Holds two first-word-fall-through FIFOs:
  - input FIFO: host pushes, CPU pops.
  - output FIFO: CPU pushes, host drains over valid/ready.
- Decouples CPU input/output instructions from host timing.
- Flags overflow and underflow with sticky error bits.

Parameters:
- DEPTH, 8: entries per FIFO; power of two, at least 2.
- WIDTH, 64: data word width; matches the CPU register width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_in_signal  input  1  CPU input-read strobe; a rising edge consumes one input word.
- cpu_in_data  output  WIDTH  head of the input FIFO; 0 when empty.
- cpu_out_signal  input  1  CPU output-write strobe; a rising edge pushes cpu_out_data.
- cpu_out_data  input  WIDTH  word written by the CPU.
- host_in_valid  input  1  host offers host_in_data.
- host_in_ready  output  1  input FIFO not full.
- host_in_data  input  WIDTH  host word to the input FIFO.
- host_out_valid  output  1  output FIFO not empty.
- host_out_ready  input  1  host accepts host_out_data.
- host_out_data  output  WIDTH  head of the output FIFO; 0 when empty.
- in_count  output  $clog2(DEPTH)+1  input FIFO occupancy.
- out_count  output  $clog2(DEPTH)+1  output FIFO occupancy.
- overflow  output  1  sticky: CPU wrote while the output FIFO was full.
- underflow  output  1  sticky: CPU read while the input FIFO was empty.
- clear_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - pointers and counts go to 0; host_in_ready=1; host_out_valid=0.
  - cpu_in_data=0, host_out_data=0, overflow=0, underflow=0.
  - edge-detect registers go to 0.
  - FIFO contents are discarded, including mid-transfer; the first edge after release behaves as a fresh start.
- Strobe edge detection:
  - cpu_in_signal and cpu_out_signal are registered as prev_in and prev_out.
  - An event is signal & ~prev, so a strobe held high for several cycles counts once.
  - A strobe already high when reset releases counts as a new edge.
- Storage and pointers:
  - Each FIFO is a DEPTH x WIDTH register array.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count is a separate register, 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Output ports are combinational from state:
  - cpu_in_data and host_out_data are mem[rd_ptr] when non-empty, else 0.
  - host_in_ready = ~in_full; host_out_valid = ~out_empty.
- Input FIFO:
  - push when host_in_valid & host_in_ready.
  - pop on an in-edge when not empty.
  - simultaneous push and pop: both occur and the count is unchanged.
  - in-edge while empty: no pop, underflow <= 1, count stays 0.
  - push while full cannot happen because ready is low.
- Output FIFO:
  - host pop when host_out_valid & host_out_ready.
  - CPU push on an out-edge, accepted when ~out_full OR a host pop occurs in the same cycle.
  - when full with a simultaneous host pop, both occur and count stays DEPTH.
  - out-edge when full with no pop: word dropped, overflow <= 1, FIFO unchanged.
- Latency:
  - a word accepted on edge N appears on the consumer side (cpu_in_data or host_out_data/valid) after edge N.
  - a pop on edge N exposes the next word after edge N.
- Sticky errors:
  - clear_err=1 clears both flags on the next edge.
  - if an error event occurs in the same cycle as clear_err, the set wins.
- The block never stalls the CPU. Callers must check in_count, or the sticky flags, to detect loss.

Test Plan:
- Reset, then host pushes 0x11, 0x22, 0x33 on consecutive cycles -> in_count=3 and cpu_in_data=0x11. A single-cycle cpu_in_signal pulse gives cpu_in_data=0x22 the next cycle. cpu_in_signal held high 4 cycles pops only once (in_count=1).
- CPU pulses cpu_out_signal 8 times with data 1..8 while host_out_ready=0 -> out_count=8. A 9th pulse with 0x99 sets overflow=1 and leaves out_count=8. Draining gives 1..8 in order, then host_out_valid=0.
- Output FIFO full, out-edge with 0xAA coincident with host pop -> host receives 1. out_count stays 8, overflow stays 0, and 0xAA is the last word drained.
- cpu_in_signal pulse with the input FIFO empty -> underflow=1 and cpu_in_data=0. clear_err pulse gives underflow=0 the next cycle. clear_err coincident with another empty read leaves underflow=1.
- Push 12 words through each FIFO with interleaved pushes and pops -> data order is preserved across pointer wrap and counts never exceed 8.
- Assert reset=0 asynchronously mid-drain with out_count=5 -> counts=0, host_out_valid=0 and host_out_data=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_buffer.sv
// CPU I/O port buffer: host->CPU input FIFO and CPU->host output FIFO, both
// first-word-fall-through, with strobe edge detection and sticky loss flags.

module io_port_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rd_ptr, wr_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage is not reset: empty FIFOs mask stale contents at the output.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module io_port_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_in_signal,
  output logic [WIDTH-1:0]       cpu_in_data,
  input  logic                   cpu_out_signal,
  input  logic [WIDTH-1:0]       cpu_out_data,
  input  logic                   host_in_valid,
  output logic                   host_in_ready,
  input  logic [WIDTH-1:0]       host_in_data,
  output logic                   host_out_valid,
  input  logic                   host_out_ready,
  output logic [WIDTH-1:0]       host_out_data,
  output logic [$clog2(DEPTH):0] in_count,
  output logic [$clog2(DEPTH):0] out_count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clear_err
);
  logic prev_in, prev_out;
  logic in_edge, out_edge;
  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic uf_set, of_set;

  // prev_* clear on reset so a strobe held across release counts as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_in  <= 1'b0;
      prev_out <= 1'b0;
    end else begin
      prev_in  <= cpu_in_signal;
      prev_out <= cpu_out_signal;
    end
  end

  assign in_edge  = cpu_in_signal  & ~prev_in;
  assign out_edge = cpu_out_signal & ~prev_out;

  assign host_in_ready  = ~in_full;
  assign host_out_valid = ~out_empty;

  assign in_push  = host_in_valid & ~in_full;
  assign in_pop   = in_edge & ~in_empty;
  assign uf_set   = in_edge & in_empty;

  // A full output FIFO still takes the CPU word when the host frees a slot
  // on the same edge.
  assign out_pop  = host_out_ready & ~out_empty;
  assign out_push = out_edge & (~out_full | out_pop);
  assign of_set   = out_edge & out_full & ~out_pop;

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (host_in_data),
    .rdata (cpu_in_data),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  io_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (cpu_out_data),
    .rdata (host_out_data),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // Set beats clear so a loss coincident with clear_err is never hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= of_set | (overflow  & ~clear_err);
      underflow <= uf_set | (underflow & ~clear_err);
    end
  end
endmodule

// File: tb/tb_io_port_buffer.sv
// Directed and random checks of io_port_buffer against a queue-based model.

module tb_io_port_buffer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 64;

  logic             clk;
  logic             reset;
  logic             cpu_in_signal;
  logic [WIDTH-1:0] cpu_in_data;
  logic             cpu_out_signal;
  logic [WIDTH-1:0] cpu_out_data;
  logic             host_in_valid;
  logic             host_in_ready;
  logic [WIDTH-1:0] host_in_data;
  logic             host_out_valid;
  logic             host_out_ready;
  logic [WIDTH-1:0] host_out_data;
  logic [3:0]       in_count;
  logic [3:0]       out_count;
  logic             overflow;
  logic             underflow;
  logic             clear_err;

  io_port_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_in_signal  (cpu_in_signal),
    .cpu_in_data    (cpu_in_data),
    .cpu_out_signal (cpu_out_signal),
    .cpu_out_data   (cpu_out_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .in_count       (in_count),
    .out_count      (out_count),
    .overflow       (overflow),
    .underflow      (underflow),
    .clear_err      (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain queues plus last-seen strobe levels and flags.
  logic [WIDTH-1:0] in_q[$];
  logic [WIDTH-1:0] out_q[$];
  bit m_prev_in, m_prev_out, m_uf, m_of;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    out_q.delete();
    m_prev_in = 0; m_prev_out = 0; m_uf = 0; m_of = 0;
  endtask

  // Advance the model by one clock edge using the inputs now applied,
  // then let the DUT take the same edge.
  task automatic tick();
    bit ie, oe, hpush, hpop, was_full, uf_set, of_set;
    ie       = cpu_in_signal  && !m_prev_in;
    oe       = cpu_out_signal && !m_prev_out;
    hpush    = host_in_valid  && (in_q.size() < DEPTH);
    hpop     = host_out_ready && (out_q.size() != 0);
    was_full = (out_q.size() == DEPTH);
    uf_set = 0; of_set = 0;
    if (ie) begin
      if (in_q.size() != 0) void'(in_q.pop_front());
      else uf_set = 1;
    end
    if (hpush) in_q.push_back(host_in_data);
    if (hpop) void'(out_q.pop_front());
    if (oe) begin
      if (!was_full || hpop) out_q.push_back(cpu_out_data);
      else of_set = 1;
    end
    m_uf = uf_set ? 1'b1 : (clear_err ? 1'b0 : m_uf);
    m_of = of_set ? 1'b1 : (clear_err ? 1'b0 : m_of);
    m_prev_in  = cpu_in_signal;
    m_prev_out = cpu_out_signal;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("cpu_in_data",    cpu_in_data,    (in_q.size()  != 0) ? in_q[0]  : 64'h0);
    chk("host_out_data",  host_out_data,  (out_q.size() != 0) ? out_q[0] : 64'h0);
    chk("host_in_ready",  64'(host_in_ready),  64'(in_q.size() < DEPTH));
    chk("host_out_valid", 64'(host_out_valid), 64'(out_q.size() != 0));
    chk("in_count",       64'(in_count),  64'(in_q.size()));
    chk("out_count",      64'(out_count), 64'(out_q.size()));
    chk("overflow",       64'(overflow),  64'(m_of));
    chk("underflow",      64'(underflow), 64'(m_uf));
  endtask

  task automatic tick_chk();
    tick();
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    cpu_in_signal = 0; cpu_out_signal = 0; cpu_out_data = '0;
    host_in_valid = 0; host_in_data = '0; host_out_ready = 0; clear_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_count",   64'(in_count), 64'd0);
    chk("rst_out_count",  64'(out_count), 64'd0);
    chk("rst_in_ready",   64'(host_in_ready), 64'd1);
    chk("rst_out_valid",  64'(host_out_valid), 64'd0);
    chk("rst_cpu_in",     cpu_in_data, 64'd0);
    chk("rst_host_out",   host_out_data, 64'd0);
    chk("rst_flags",      64'({overflow, underflow}), 64'd0);
    #2 reset = 1'b1;

    // host fills input FIFO; CPU pops with a pulse and with a held strobe
    host_in_valid = 1;
    host_in_data = 64'h11; tick_chk();
    host_in_data = 64'h22; tick_chk();
    host_in_data = 64'h33; tick_chk();
    host_in_valid = 0;
    chk("in3_count", 64'(in_count), 64'd3);
    chk("in3_head",  cpu_in_data, 64'h11);
    cpu_in_signal = 1; tick_chk();
    cpu_in_signal = 0; tick_chk();
    chk("pulse_head", cpu_in_data, 64'h22);
    cpu_in_signal = 1;
    repeat (4) tick_chk();
    cpu_in_signal = 0; tick_chk();
    chk("held_once", 64'(in_count), 64'd1);
    cpu_in_signal = 1; tick_chk();
    cpu_in_signal = 0; tick_chk();

    // output FIFO fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) begin
      cpu_out_data = 64'(i);
      cpu_out_signal = 1; tick_chk();
      cpu_out_signal = 0; tick_chk();
    end
    chk("out_full_count", 64'(out_count), 64'd8);
    cpu_out_data = 64'h99;
    cpu_out_signal = 1; tick_chk();
    cpu_out_signal = 0; tick_chk();
    chk("ovf_set",   64'(overflow), 64'd1);
    chk("ovf_count", 64'(out_count), 64'd8);
    host_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", host_out_data, 64'(i));
      tick_chk();
    end
    host_out_ready = 0;
    chk("drained_valid", 64'(host_out_valid), 64'd0);
    clear_err = 1; tick_chk();
    clear_err = 0;

    // full FIFO with simultaneous CPU push and host pop
    for (int i = 1; i <= 8; i++) begin
      cpu_out_data = 64'(i);
      cpu_out_signal = 1; tick_chk();
      cpu_out_signal = 0; tick_chk();
    end
    cpu_out_data = 64'hAA; cpu_out_signal = 1; host_out_ready = 1;
    chk("coinc_head", host_out_data, 64'h1);
    tick_chk();
    cpu_out_signal = 0; host_out_ready = 0;
    chk("coinc_count", 64'(out_count), 64'd8);
    chk("coinc_ovf",   64'(overflow), 64'd0);
    host_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("coinc_drain", host_out_data, (i < 7) ? 64'(i + 2) : 64'hAA);
      tick_chk();
    end
    host_out_ready = 0;

    // underflow, clear, and set-beats-clear
    cpu_in_signal = 1; tick_chk();
    cpu_in_signal = 0; tick_chk();
    chk("uf_set",   64'(underflow), 64'd1);
    chk("uf_data",  cpu_in_data, 64'd0);
    clear_err = 1; tick_chk();
    clear_err = 0;
    chk("uf_clear", 64'(underflow), 64'd0);
    clear_err = 1; cpu_in_signal = 1; tick_chk();
    clear_err = 0; cpu_in_signal = 0;
    chk("uf_set_wins", 64'(underflow), 64'd1);
    clear_err = 1; tick_chk();
    clear_err = 0;

    // randomized traffic across pointer wrap, two load profiles
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 250; c++) begin
        host_in_valid  = ($urandom_range(0, 3) != 0) ^ (ph == 1);
        host_in_data   = {$urandom, $urandom};
        cpu_in_signal  = ($urandom_range(0, 1) == 0);
        cpu_out_signal = ($urandom_range(0, 1) == 0);
        cpu_out_data   = {$urandom, $urandom};
        host_out_ready = ($urandom_range(0, 3) == 0) ^ (ph == 1);
        clear_err      = ($urandom_range(0, 15) == 0);
        tick_chk();
        chk("rand_cnt_bound", 64'((in_count <= 8) && (out_count <= 8)), 64'd1);
      end
    end
    cpu_in_signal = 0; cpu_out_signal = 0; host_in_valid = 0;
    host_out_ready = 1; clear_err = 0;
    repeat (DEPTH + 1) tick_chk();
    host_out_ready = 0;

    // asynchronous reset mid-drain
    for (int i = 0; i < 6; i++) begin
      cpu_out_data = 64'(16'hC0 + i);
      cpu_out_signal = 1; tick_chk();
      cpu_out_signal = 0; tick_chk();
    end
    host_out_ready = 1; tick_chk();
    chk("pre_rst_count", 64'(out_count), 64'd5);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_out_count", 64'(out_count), 64'd0);
    chk("arst_in_count",  64'(in_count), 64'd0);
    chk("arst_valid",     64'(host_out_valid), 64'd0);
    chk("arst_data",      host_out_data, 64'd0);
    chk("arst_ready",     64'(host_in_ready), 64'd1);
    host_out_ready = 0;
    cpu_in_signal = 1;
    #3 reset = 1'b1;
    tick_chk();
    chk("held_strobe_edge", 64'(underflow), 64'd1);
    cpu_in_signal = 0; tick_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
